// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter for two requesters sharing one synchronous single-port SRAM.
// After reset, the whole array is swept to INIT_VAL before any request is granted.
module sram_port_arbiter #(
  parameter int                   AddressSize = 8,
  parameter int                   DataSize    = 16,
  parameter logic [DataSize-1:0]  INIT_VAL    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   wr0,
  input  logic [AddressSize-1:0] addr0,
  input  logic [DataSize-1:0]    wdata0,
  output logic                   gnt0,
  output logic                   rvalid0,
  input  logic                   req1,
  input  logic                   wr1,
  input  logic [AddressSize-1:0] addr1,
  input  logic [DataSize-1:0]    wdata1,
  output logic                   gnt1,
  output logic                   rvalid1,
  output logic [DataSize-1:0]    rdata,
  output logic                   init_done,
  output logic [AddressSize-1:0] mem_addr,
  output logic [DataSize-1:0]    mem_data,
  output logic                   mem_we_n,
  input  logic [DataSize-1:0]    mem_q
);

  // state | meaning
  // INIT  | sweeping every address to INIT_VAL, no grants
  // ARB   | round-robin arbitration of req0/req1
  typedef enum logic {ST_INIT, ST_ARB} state_e;

  state_e                 state_q, state_d;
  logic [AddressSize-1:0] cnt_q, cnt_d;
  logic                   prio_q, prio_d;   // 0: port0 wins a tie, 1: port1 wins
  logic                   init_done_q, init_done_d;
  logic                   rvalid0_q, rvalid0_d;
  logic                   rvalid1_q, rvalid1_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
      init_done_q <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      init_done_q <= init_done_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    init_done_d = init_done_q;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    mem_addr    = '0;
    mem_data    = '0;
    mem_we_n    = 1'b1;
    // Reset gates the SRAM strobe and grants so no write lands while rst is high.
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          mem_addr = cnt_q;
          mem_data = INIT_VAL;
          mem_we_n = 1'b0;
          cnt_d    = cnt_q + AddressSize'(1);
          if (&cnt_q) begin
            state_d     = ST_ARB;
            init_done_d = 1'b1;
          end
        end
        ST_ARB: begin
          gnt0 = req0 & (~req1 | ~prio_q);
          gnt1 = req1 & (~req0 |  prio_q);
          if (gnt0) begin
            mem_addr  = addr0;
            mem_data  = wdata0;
            mem_we_n  = ~wr0;
            rvalid0_d = ~wr0;
            prio_d    = 1'b1;
          end else if (gnt1) begin
            mem_addr  = addr1;
            mem_data  = wdata1;
            mem_we_n  = ~wr1;
            rvalid1_d = ~wr1;
            prio_d    = 1'b0;
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  // Masking with rst also drops a read return that was due in the reset cycle.
  assign rvalid0   = rvalid0_q & ~rst;
  assign rvalid1   = rvalid1_q & ~rst;
  assign init_done = init_done_q & ~rst;
  assign rdata     = mem_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a read-data scoreboard.
module tb_sram_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk, rst;
  logic          req0, wr0, req1, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic [AW-1:0] mem_addr;
  logic          mem_we_n;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram [256];
  logic [AW-1:0] sram_addr_r;
  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  sram_port_arbiter #(.AddressSize(AW), .DataSize(DW), .INIT_VAL('0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .init_done(init_done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we_n(mem_we_n), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) sram[i] = 16'hDEAD;
  always @(posedge clk) begin
    if (!mem_we_n) sram[mem_addr] <= mem_data;
    sram_addr_r <= mem_addr;
  end
  assign mem_q = sram[sram_addr_r];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expects to be entered just after a posedge with the sweep at address 0.
  task automatic sweep(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("sweep_we_n", mem_we_n, 0);
      chk("sweep_addr", mem_addr, i);
      chk("sweep_data", mem_data, 0);
      chk("sweep_gnt0", gnt0, 0);
      chk("sweep_init_done", init_done, 0);
      next_cycle();
    end
  endtask

  // Scoreboard: reads push the reference memory value on grant, pop on rvalid.
  always @(negedge clk) begin
    chk("gnt_exclusive", gnt0 & gnt1, 0);
    chk("rvalid_exclusive", rvalid0 & rvalid1, 0);
    if (rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", rvalid0, 0);
      else chk("rdata0", rdata, q0.pop_front());
    end
    if (rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", rvalid1, 0);
      else chk("rdata1", rdata, q1.pop_front());
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    end else begin
      if (gnt0) begin
        if (wr0) exp_mem[addr0] = wdata0;
        else     q0.push_back(exp_mem[addr0]);
      end
      if (gnt1) begin
        if (wr1) exp_mem[addr1] = wdata1;
        else     q1.push_back(exp_mem[addr1]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'hA5; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0;    wdata1 = '0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_we_n", mem_we_n, 1);
      chk("rst_gnt0", gnt0, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_rvalid0", rvalid0, 0);
    end
    next_cycle();
    rst = 1'b0;
    sweep(256);

    // First ARB cycle: the request held through the sweep is granted.
    @(negedge clk);
    chk("arb_init_done", init_done, 1);
    chk("arb_first_gnt0", gnt0, 1);
    chk("arb_first_addr", mem_addr, 8'hA5);
    chk("arb_first_we_n", mem_we_n, 1);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    chk("read_a5_rvalid0", rvalid0, 1);
    chk("read_a5_rdata", rdata, 16'h0000);

    // Port0 write then back-to-back read of the same address.
    next_cycle();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h12; wdata0 = 16'hBEEF;
    @(negedge clk);
    chk("wr12_gnt0", gnt0, 1);
    chk("wr12_we_n", mem_we_n, 0);
    chk("wr12_addr", mem_addr, 8'h12);
    chk("wr12_data", mem_data, 16'hBEEF);
    next_cycle();
    wr0 = 1'b0;
    @(negedge clk);
    chk("rd12_gnt0", gnt0, 1);
    chk("rd12_we_n", mem_we_n, 1);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    chk("rd12_rvalid0", rvalid0, 1);
    chk("rd12_rdata", rdata, 16'hBEEF);

    // Preload 0x01/0x02; ending on a port1 grant leaves port0 with priority.
    next_cycle();
    req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h01; wdata0 = 16'h1111;
    @(negedge clk);
    chk("pre01_gnt0", gnt0, 1);
    next_cycle();
    req0 = 1'b0;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h02; wdata1 = 16'h2222;
    @(negedge clk);
    chk("pre02_gnt1", gnt1, 1);
    chk("pre02_we_n", mem_we_n, 0);

    // Both ports reading continuously: strict alternation starting at port0.
    next_cycle();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h01;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h02;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("alt_gnt0", gnt0, (k % 2 == 0));
      chk("alt_gnt1", gnt1, (k % 2 == 1));
      if (k > 0) begin
        chk("alt_rvalid0", rvalid0, ((k - 1) % 2 == 0));
        chk("alt_rvalid1", rvalid1, ((k - 1) % 2 == 1));
      end
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("alt_last_rvalid1", rvalid1, 1);
    chk("alt_last_rdata", rdata, 16'h2222);

    // Lone port0 read hands priority to port1 for the collision below.
    next_cycle();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h01;
    @(negedge clk);
    chk("solo_gnt0", gnt0, 1);
    next_cycle();
    addr0 = 8'h40;
    req1 = 1'b1; wr1 = 1'b1; addr1 = 8'h40; wdata1 = 16'h5A5A;
    @(negedge clk);
    chk("coll_gnt1", gnt1, 1);
    chk("coll_gnt0", gnt0, 0);
    chk("coll_we_n", mem_we_n, 0);
    chk("coll_rvalid0", rvalid0, 1);
    next_cycle();
    req1 = 1'b0;
    @(negedge clk);
    chk("coll_next_gnt0", gnt0, 1);
    chk("coll_next_addr", mem_addr, 8'h40);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    chk("coll_rvalid0_raw", rvalid0, 1);
    chk("coll_rdata_raw", rdata, 16'h5A5A);

    // Reset in the cycle after a read grant: the return is suppressed.
    next_cycle();
    req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h12;
    @(negedge clk);
    chk("pre_rst_gnt0", gnt0, 1);
    next_cycle();
    req0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midarb_rvalid0", rvalid0, 0);
    chk("midarb_init_done", init_done, 0);
    chk("midarb_we_n", mem_we_n, 1);
    next_cycle();
    rst = 1'b0;
    req0 = 1'b1;
    sweep(100);

    // Reset at sweep address 100: no write that cycle, sweep restarts at 0.
    rst = 1'b1;
    @(negedge clk);
    chk("midinit_we_n", mem_we_n, 1);
    chk("midinit_gnt0", gnt0, 0);
    chk("midinit_init_done", init_done, 0);
    next_cycle();
    rst = 1'b0;
    sweep(256);

    @(negedge clk);
    chk("resweep_init_done", init_done, 1);
    chk("resweep_gnt0", gnt0, 1);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    chk("resweep_rvalid0", rvalid0, 1);
    chk("resweep_rdata", rdata, 16'h0000);
    next_cycle();
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester round-robin arbiter and initialiser in front of the synchronous single-port SRAM.
- SRAM contract: writes at the posedge when write-enable (active-low) is low; address registered every posedge; read data valid combinationally the cycle after the address is presented.
- After reset the block sweeps the whole array to INIT_VAL. It then shares the single SRAM port between two requesters, one access per cycle, and returns read data with a valid strobe.

Parameters:
AddressSize  8  SRAM address width; array swept over 0 .. 2^AddressSize-1
DataSize  16  SRAM data width
INIT_VAL  0  DataSize-wide value written to every location after reset

Ports:
clk  input  1  single clock, all state on posedge
rst  input  1  synchronous, active-high reset
req0  input  1  port 0 access request; held until granted
wr0  input  1  port 0: 1 = write, 0 = read (valid with req0)
addr0  input  AddressSize  port 0 address
wdata0  input  DataSize  port 0 write data
gnt0  output  1  port 0 request accepted this cycle
rvalid0  output  1  port 0 read data on rdata this cycle
req1, wr1, addr1, wdata1, gnt1, rvalid1  same as port 0, for port 1
rdata  output  DataSize  read data, shared; qualified by rvalid0/rvalid1
init_done  output  1  sweep complete, arbitration active
mem_addr  output  AddressSize  to SRAM Address
mem_data  output  DataSize  to SRAM Data
mem_we_n  output  1  to SRAM WE, active-low
mem_q  input  DataSize  from SRAM q

Behaviour:
- Reset state while rst=1: state=INIT, cnt=0, init_done=0, rvalid0/1=0, prio=port0, mem_we_n=1, gnt0/1=0. No SRAM write occurs in a cycle with rst=1.
- FSM states: INIT, ARB.
- INIT, each cycle:
  - mem_addr=cnt, mem_data=INIT_VAL, mem_we_n=0, gnt0/1=0.
  - cnt increments by 1. cnt is AddressSize bits wide.
  - On the cycle with cnt = all-ones, the write completes and the next state is ARB. init_done is registered high from the first ARB cycle.
  - Sweep length is exactly 2^AddressSize cycles after rst deasserts.
  - Requests during INIT are not granted. Requesters keep them held.
- ARB, grant logic (combinational from req0/req1/prio):
  - Only req0: gnt0=1. Only req1: gnt1=1.
  - Both: grant goes to the port selected by prio.
  - Neither: no grant; mem_we_n=1, mem_addr=0, mem_data=0.
  - Never gnt0 & gnt1 together.
- ARB, SRAM drive: mem_addr/mem_data come from the granted port. mem_we_n = ~wr of the granted port. The write lands at that posedge.
- ARB, priority update: after a grant to port i, prio = the other port (registered). With no grant, prio holds. Both requesting continuously gives strict alternation. A lone requester is granted every cycle, back-to-back.
- Handshake: a request is consumed at the posedge where req_i & gnt_i. The requester may present a new request (different addr/wr) in the very next cycle.
- Read return:
  - rvalid_i is registered = gnt_i & ~wr_i.
  - rdata = mem_q, combinational passthrough.
  - Latency: read granted in cycle N gives rvalid_i and rdata in cycle N+1.
  - At most one rvalid high per cycle.
  - rdata is don't-care when no rvalid is high.
- Read-after-write to the same address in consecutive cycles returns the new data.
- A write has no completion strobe; gnt is the acknowledgement.
- rst asserted mid-ARB:
  - Takes effect at that posedge.
  - Any rvalid due the next cycle is suppressed (forced 0).
  - prio returns to port0 and a full sweep restarts.
- rst asserted mid-INIT: cnt returns to 0 and the sweep restarts from address 0.

Test Plan:
- Reset, release; check: mem_we_n=0 for exactly 256 cycles with mem_addr 0..255, init_done=1 in cycle 257. Then port0 reads 0xA5 -> rvalid0 next cycle, rdata=0x0000.
- ARB, port0 alone: write 0x12 <- 0xBEEF, then read 0x12 the next cycle -> gnt0 both cycles, rvalid0 one cycle after the read grant, rdata=0xBEEF.
- Both ports request continuous reads (port0 addr 0x01, port1 addr 0x02; preloaded 0x1111/0x2222) -> grants gnt0,gnt1,gnt0,... starting with port0. rvalid alternates one cycle later with rdata 0x1111/0x2222. Never both gnt high.
- Port1 write 0x40 <- 0x5A5A while port0 reads 0x40 in the same cycle with prio=port1 -> port1 granted first. Port0 granted next cycle and reads 0x5A5A.
- req0 held high during INIT -> gnt0=0 throughout. First ARB cycle: gnt0=1.
- rst pulsed 1 cycle at sweep address 100, and again in the cycle after a read grant -> sweep restarts at 0 (256 more write cycles), pending rvalid suppressed, init_done=0 until the sweep finishes.
